// File: rtl/alu_iter.sv
// Handshaked ALU with iterative multiply/divide and {err, v, c, z} status flags.
// Define ALU_ITER_MULDIV_EN to build MUL/DIV; otherwise those opcodes are illegal.
module alu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] res;
    logic             err, cf, vf;

    assign sum_ext = {1'b0, a} + {1'b0, b};
    assign dif     = a - b;

    // Result of every op that completes in the accept cycle.
    always_comb begin
        res = '0;
        err = 1'b0;
        cf  = 1'b0;
        vf  = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum_ext[WIDTH-1:0];
                cf  = sum_ext[WIDTH];
                vf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = dif;
                cf  = a < b;
                vf  = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
`ifdef ALU_ITER_MULDIV_EN
            OP_MUL: res = '0;
            OP_DIV: begin
                // Only reaches DONE from here when b == 0.
                res = '1;
                err = 1'b1;
            end
`endif
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_SHL: res = a << b[SHW-1:0];
            OP_SHR: res = a >> b[SHW-1:0];
            default: err = 1'b1;
        endcase
    end

`ifdef ALU_ITER_MULDIV_EN
    // acc holds {partial product, multiplier} for MUL, {remainder, dividend/quotient} for DIV.
    logic [2*WIDTH-1:0] acc_q, acc_d, mul_step, div_step;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               is_mul_q, is_mul_d;
    logic [WIDTH:0]     mul_sum, div_trial;

    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                     + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    assign mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    assign div_step  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        flags_d = flags_q;
`ifdef ALU_ITER_MULDIV_EN
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = DONE;
                    out_d   = res;
                    flags_d = {err, vf, cf, res == '0};
`ifdef ALU_ITER_MULDIV_EN
                    if (op == OP_MUL || (op == OP_DIV && b != '0)) begin
                        state_d  = BUSY;
                        cnt_d    = '0;
                        is_mul_d = (op == OP_MUL);
                        acc_d    = (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
                        opnd_d   = (op == OP_MUL) ? a : b;
                    end
`endif
                end
            end
`ifdef ALU_ITER_MULDIV_EN
            BUSY: begin
                acc_d = is_mul_q ? mul_step : div_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = DONE;
                    out_d   = acc_d[WIDTH-1:0];
                    flags_d = {2'b00, is_mul_q && (acc_d[2*WIDTH-1:WIDTH] != '0),
                               acc_d[WIDTH-1:0] == '0};
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= '0;
            flags_q <= '0;
`ifdef ALU_ITER_MULDIV_EN
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            flags_q <= flags_d;
`ifdef ALU_ITER_MULDIV_EN
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter with an arithmetic reference model checked every cycle.
module tb_alu_iter;

    localparam int W = 32;
`ifdef ALU_ITER_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [3:0]   flags;

    int chk  = 0;
    int errs = 0;

    alu_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        chk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode rules.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic [3:0] f, output int lat);
        longint          s;
        longint unsigned u;
        logic            e, c, v;
        e = 1'b0; c = 1'b0; v = 1'b0; r = '0; lat = 1;
        case (o)
            4'h0: begin
                u = 64'(x) + 64'(y); r = u[W-1:0]; c = u[W];
                s = longint'($signed(x)) + longint'($signed(y));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h1: begin
                r = x - y; c = x < y;
                s = longint'($signed(x)) - longint'($signed(y));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h2: begin
                if (MD) begin
                    u = 64'(x) * 64'(y); r = u[W-1:0]; c = (u[63:W] != 0); lat = W + 1;
                end else e = 1'b1;
            end
            4'h3: begin
                if (!MD) e = 1'b1;
                else if (y == 0) begin r = '1; e = 1'b1; end
                else begin r = x / y; lat = W + 1; end
            end
            4'h4: r = x & y;
            4'h5: r = x | y;
            4'h6: r = x ^ y;
            4'h7: r = ~x;
            4'h8: r = x << y[4:0];
            4'h9: r = x >> y[4:0];
            default: e = 1'b1;
        endcase
        f = {e, v, c, r == 0};
    endfunction

    // Per-cycle compare against the model's view of the handshake.
    int           cyc = 0;
    bit           pending = 0;
    bit           post_reset = 0;
    int           acc_cyc;
    int           exp_lat;
    logic [W-1:0] exp_out;
    logic [3:0]   exp_flags;
    bit           exp_valid;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            check("in_ready_in_reset", in_ready, 0);
            pending    = 0;
            post_reset = 1;
        end else begin
            if (post_reset) begin
                check("reset_out_valid", out_valid, 0);
                check("reset_out", out, 0);
                check("reset_flags", flags, 0);
                post_reset = 0;
            end
            exp_valid = pending && (cyc >= acc_cyc + exp_lat);
            check("in_ready", in_ready, !pending);
            check("out_valid", out_valid, exp_valid);
            if (exp_valid && out_valid) begin
                check("out", out, exp_out);
                check("flags", flags, exp_flags);
            end
            if (exp_valid && out_ready) pending = 0;
            else if (!pending && in_valid) begin
                pending = 1;
                acc_cyc = cyc;
                model(op, a, b, exp_out, exp_flags, exp_lat);
            end
        end
    end

    // hold < 0: out_ready raised before the result exists.
    task automatic run_op(input string nm, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int hold,
                          input logic [W-1:0] lit_out, input logic [3:0] lit_flags);
        bit rdy;
        int n;
        in_valid = 1; op = o; a = x; b = y;
        if (hold < 0) out_ready = 1;
        n = 0;
        do begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #2;
            n++;
        end while (!rdy && n < 100);
        in_valid = 0; a = $urandom; b = $urandom; op = 4'($urandom);
        if (!rdy) begin
            check({nm, ".accept_timeout"}, 0, 1);
            return;
        end
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid) begin
            check({nm, ".result_timeout"}, 0, 1);
            out_ready = 0;
            return;
        end
        check({nm, ".lit_out"}, out, lit_out);
        check({nm, ".lit_flags"}, flags, lit_flags);
        @(posedge clk); #2;
        if (hold >= 0) begin
            repeat (hold) begin @(posedge clk); #2; end
            out_ready = 1;
            @(posedge clk); #2;
        end
        out_ready = 0;
    endtask

    initial begin
        reset = 1; in_valid = 0; out_ready = 0; a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        #2 reset = 0;

        run_op("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h1, 3, 32'h0, 4'b0011);
        run_op("sub_ovf", 4'h1, 32'h8000_0000, 32'h1, 0, 32'h7FFF_FFFF, 4'b0100);
        run_op("sub_borrow", 4'h1, 32'd3, 32'd5, 0, 32'hFFFF_FFFE, 4'b0010);
        run_op("add_ovf", 4'h0, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 4'b0100);
        run_op("mul_big", 4'h2, 32'h1_0000, 32'h1_0000, 2,
               32'h0, MD ? 4'b0011 : 4'b1001);
        run_op("mul_small", 4'h2, 32'd7, 32'd6, 0, MD ? 32'd42 : 32'd0, MD ? 4'b0000 : 4'b1001);
        run_op("div", 4'h3, 32'd100, 32'd7, -1, MD ? 32'd14 : 32'd0, MD ? 4'b0000 : 4'b1001);
        run_op("div_zero", 4'h3, 32'd5, 32'd0, 0,
               MD ? 32'hFFFF_FFFF : 32'd0, MD ? 4'b1000 : 4'b1001);
        run_op("shl", 4'h8, 32'h1, 32'h25, 0, 32'h20, 4'b0000);
        run_op("shr", 4'h9, 32'h8000_0000, 32'd31, -1, 32'h1, 4'b0000);
        run_op("illegal", 4'hC, 32'h1234, 32'h5678, 0, 32'h0, 4'b1001);
        run_op("not", 4'h7, 32'h0, 32'h0, -1, 32'hFFFF_FFFF, 4'b0000);
        run_op("xor", 4'h6, 32'h5A5A, 32'h5A5A, 0, 32'h0, 4'b0001);

        // Reset during the 10th busy cycle of a multiply.
        in_valid = 1; op = 4'h2; a = 32'd9; b = 32'd9;
        @(posedge clk); #2;
        in_valid = 0;
        repeat (9) begin @(posedge clk); #2; end
        reset = 1;
        @(posedge clk); #2;
        reset = 0;
        repeat (3) begin @(posedge clk); #2; end

        run_op("and_after_reset", 4'h4, 32'hF0, 32'h3C, 0, 32'h30, 4'b0000);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end

endmodule
